// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - shared types, stream codes and config field helpers for pe_stream_scheduler
package pe_sched_pkg;

    localparam int DATA_BITS_DEF      = 32;
    localparam int CONFIG_SIZE_DEF    = 13;
    localparam int PW_IPSUM_WORDS_DEF = 4;

    localparam int CFG_DW_BIT   = 12;
    localparam int CFG_RS_LSB   = 10;
    localparam int CFG_MODE_BIT = 9;
    localparam int CFG_P_LSB    = 7;
    localparam int CFG_F_LSB    = 2;
    localparam int CFG_Q_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_FILTER,
        ST_IFMAP,
        ST_IPSUM,
        ST_PWIPSUM,
        ST_OPSUM,
        ST_DONE
    } sched_state_e;

    typedef enum logic [2:0] {
        SEL_NONE     = 3'd0,
        SEL_FILTER   = 3'd1,
        SEL_IFMAP    = 3'd2,
        SEL_DW_IPSUM = 3'd3,
        SEL_PW_IPSUM = 3'd4
    } src_sel_e;

    // Counters hold the index of the last word, so FW=16 still fits in four bits.
    function automatic logic [3:0] cfg_filter_last(input logic [CONFIG_SIZE_DEF-1:0] c);
        logic [4:0] words;
        words = (5'(c[CFG_P_LSB +: 2]) + 5'd1) * (5'(c[CFG_RS_LSB +: 2]) + 5'd1);
        return 4'(words - 5'd1);
    endfunction

    function automatic logic [1:0] cfg_ifmap_last(input logic [CONFIG_SIZE_DEF-1:0] c);
        return c[CFG_RS_LSB +: 2];
    endfunction

    function automatic logic [1:0] cfg_ipsum_last(input logic [CONFIG_SIZE_DEF-1:0] c);
        return c[CFG_DW_BIT] ? c[CFG_Q_LSB +: 2] : c[CFG_P_LSB +: 2];
    endfunction

    function automatic logic [1:0] cfg_opsum_last(input logic [CONFIG_SIZE_DEF-1:0] c);
        return c[CFG_P_LSB +: 2];
    endfunction

    function automatic logic [4:0] cfg_col_last(input logic [CONFIG_SIZE_DEF-1:0] c);
        return c[CFG_F_LSB +: 5];
    endfunction

endpackage

// File: rtl/pe_stream_scheduler_if.sv
// rtl/pe_stream_scheduler_if.sv - job, global-buffer, PE operand and opsum handshakes of pe_stream_scheduler
interface pe_stream_scheduler_if #(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 13
);
    logic                   job_valid;
    logic                   job_ready;
    logic [CONFIG_SIZE-1:0] job_config;

    logic [2:0]             src_sel;
    logic                   src_valid;
    logic                   src_ready;
    logic [DATA_BITS-1:0]   src_data;

    logic                   PE_en;
    logic [CONFIG_SIZE-1:0] i_config;

    logic [DATA_BITS-1:0]   ifmap;
    logic [DATA_BITS-1:0]   filter;
    logic [DATA_BITS-1:0]   depthwise_ipsum;
    logic [DATA_BITS-1:0]   pointwise_ipsum;
    logic                   ifmap_valid;
    logic                   filter_valid;
    logic                   depthwise_ipsum_valid;
    logic                   pointwise_ipsum_valid;
    logic                   ifmap_ready;
    logic                   filter_ready;
    logic                   depthwise_ipsum_ready;
    logic                   pointwise_ipsum_ready;

    logic [DATA_BITS-1:0]   pe_opsum;
    logic                   pe_opsum_valid;
    logic                   pe_opsum_ready;
    logic [DATA_BITS-1:0]   out_opsum;
    logic                   out_opsum_valid;
    logic                   out_opsum_ready;

    logic                   job_done;

    modport master (
        input  job_valid, job_config,
        input  src_valid, src_data,
        input  ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready,
        input  pe_opsum, pe_opsum_valid, out_opsum_ready,
        output job_ready, src_sel, src_ready, PE_en, i_config,
        output ifmap, filter, depthwise_ipsum, pointwise_ipsum,
        output ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid,
        output pe_opsum_ready, out_opsum, out_opsum_valid, job_done
    );

    modport slave (
        output job_valid, job_config,
        output src_valid, src_data,
        output ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready,
        output pe_opsum, pe_opsum_valid, out_opsum_ready,
        input  job_ready, src_sel, src_ready, PE_en, i_config,
        input  ifmap, filter, depthwise_ipsum, pointwise_ipsum,
        input  ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid,
        input  pe_opsum_ready, out_opsum, out_opsum_valid, job_done
    );

endinterface

// File: rtl/pe_sched_word_counter.sv
// rtl/pe_sched_word_counter.sv - per-phase transfer counter with loadable last index and terminal flag
module pe_sched_word_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] last_idx,
    input  logic             fire,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last_q;

    assign done = fire && (count == last_q);

    // Wraps to zero on the terminal transfer so per-column phases reuse the same load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            last_q <= '0;
        end else if (load) begin
            count  <= '0;
            last_q <= last_idx;
        end else if (fire) begin
            count <= done ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pe_stream_scheduler.sv
// rtl/pe_stream_scheduler.sv - per-PE job sequencer: filter, per-column ifmap/ipsum/pw-ipsum, opsum drain; PE_SCHED_PERF_EN adds stall_cycles
module pe_stream_scheduler
    import pe_sched_pkg::*;
#(
    parameter int PW_IPSUM_WORDS = PW_IPSUM_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PE_SCHED_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    pe_stream_scheduler_if.master bus
);

    localparam int PW_W = (PW_IPSUM_WORDS > 1) ? $clog2(PW_IPSUM_WORDS) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PW_IPSUM_WORDS - 1);

    sched_state_e state_q, state_d;

    logic accept;
    logic filter_fire, ifmap_fire, ipsum_fire, pw_fire, opsum_fire;
    logic filter_done, ifmap_done, ipsum_done, pw_done, opsum_done, col_done;
    logic depthwise_q;

    assign accept      = (state_q == ST_IDLE) && bus.job_valid;
    assign depthwise_q = bus.i_config[CFG_DW_BIT];

    assign filter_fire = (state_q == ST_FILTER)  && bus.src_valid && bus.filter_ready;
    assign ifmap_fire  = (state_q == ST_IFMAP)   && bus.src_valid && bus.ifmap_ready;
    assign ipsum_fire  = (state_q == ST_IPSUM)   && bus.src_valid && bus.depthwise_ipsum_ready;
    assign pw_fire     = (state_q == ST_PWIPSUM) && bus.src_valid && bus.pointwise_ipsum_ready;
    assign opsum_fire  = (state_q == ST_OPSUM)   && bus.pe_opsum_valid && bus.out_opsum_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bus.i_config <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bus.i_config <= bus.job_config;
            end
        end
    end

    pe_sched_word_counter #(.WIDTH(4)) u_filter_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(cfg_filter_last(bus.job_config)),
        .fire(filter_fire), .done(filter_done)
    );

    pe_sched_word_counter #(.WIDTH(2)) u_ifmap_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(cfg_ifmap_last(bus.job_config)),
        .fire(ifmap_fire), .done(ifmap_done)
    );

    pe_sched_word_counter #(.WIDTH(2)) u_ipsum_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(cfg_ipsum_last(bus.job_config)),
        .fire(ipsum_fire), .done(ipsum_done)
    );

    pe_sched_word_counter #(.WIDTH(PW_W)) u_pw_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(PW_LAST),
        .fire(pw_fire), .done(pw_done)
    );

    pe_sched_word_counter #(.WIDTH(2)) u_opsum_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(cfg_opsum_last(bus.job_config)),
        .fire(opsum_fire), .done(opsum_done)
    );

    // Steps once per drained column; its terminal flag marks the final column.
    pe_sched_word_counter #(.WIDTH(5)) u_col_cnt (
        .clk(clk), .rst(rst), .load(accept),
        .last_idx(cfg_col_last(bus.job_config)),
        .fire(opsum_done), .done(col_done)
    );

    always_comb begin
        state_d             = state_q;
        bus.job_ready       = 1'b0;
        bus.PE_en           = 1'b0;
        bus.job_done        = 1'b0;
        bus.src_sel         = SEL_NONE;
        bus.pe_opsum_ready  = 1'b0;
        bus.out_opsum_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.job_ready = 1'b1;
                if (bus.job_valid) state_d = ST_CFG;
            end
            ST_CFG: begin
                bus.PE_en = 1'b1;
                state_d   = ST_FILTER;
            end
            ST_FILTER: begin
                bus.src_sel = SEL_FILTER;
                if (filter_done) state_d = ST_IFMAP;
            end
            ST_IFMAP: begin
                bus.src_sel = SEL_IFMAP;
                if (ifmap_done) state_d = ST_IPSUM;
            end
            ST_IPSUM: begin
                bus.src_sel = SEL_DW_IPSUM;
                if (ipsum_done) state_d = depthwise_q ? ST_PWIPSUM : ST_OPSUM;
            end
            ST_PWIPSUM: begin
                bus.src_sel = SEL_PW_IPSUM;
                if (pw_done) state_d = ST_OPSUM;
            end
            ST_OPSUM: begin
                bus.pe_opsum_ready  = bus.out_opsum_ready;
                bus.out_opsum_valid = bus.pe_opsum_valid;
                if (opsum_done) state_d = col_done ? ST_DONE : ST_IFMAP;
            end
            ST_DONE: begin
                bus.job_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.filter_valid          = 1'b0;
        bus.ifmap_valid           = 1'b0;
        bus.depthwise_ipsum_valid = 1'b0;
        bus.pointwise_ipsum_valid = 1'b0;
        bus.src_ready             = 1'b0;
        unique case (bus.src_sel)
            SEL_FILTER: begin
                bus.filter_valid = bus.src_valid;
                bus.src_ready    = bus.filter_ready;
            end
            SEL_IFMAP: begin
                bus.ifmap_valid = bus.src_valid;
                bus.src_ready   = bus.ifmap_ready;
            end
            SEL_DW_IPSUM: begin
                bus.depthwise_ipsum_valid = bus.src_valid;
                bus.src_ready             = bus.depthwise_ipsum_ready;
            end
            SEL_PW_IPSUM: begin
                bus.pointwise_ipsum_valid = bus.src_valid;
                bus.src_ready             = bus.pointwise_ipsum_ready;
            end
            default: bus.src_ready = 1'b0;
        endcase
    end

    assign bus.filter          = bus.src_data;
    assign bus.ifmap           = bus.src_data;
    assign bus.depthwise_ipsum = bus.src_data;
    assign bus.pointwise_ipsum = bus.src_data;
    assign bus.out_opsum       = bus.pe_opsum;

`ifdef PE_SCHED_PERF_EN
    logic phase_active;
    logic phase_fire;

    assign phase_active = state_q inside {ST_FILTER, ST_IFMAP, ST_IPSUM, ST_PWIPSUM, ST_OPSUM};
    assign phase_fire   = filter_fire | ifmap_fire | ipsum_fire | pw_fire | opsum_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (phase_active && !phase_fire && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
